// File: rtl/mem_bridge_if.sv
// ---------------------------------------------------------------------------
// mem_bridge_if
//   Bundles the datapath-side request/response handshake and the RAM-side
//   port of mem_bridge.
//
//   Datapath side : Req, Wr, Size, Address, WriteData  -> bridge
//                   Ready, Done, ReadData, AlignErr, State <- bridge
//   RAM side      : RamAddr, RamWr, RamDatain          <- bridge
//                   RamDataout                         -> bridge
//
//   Modports:
//     slave  - the bridge itself
//     master - whoever drives requests and models the RAM
// ---------------------------------------------------------------------------
interface mem_bridge_if;
  logic        Req;
  logic        Wr;
  logic [1:0]  Size;
  logic [31:0] Address;
  logic [31:0] WriteData;
  logic        Ready;
  logic        Done;
  logic [31:0] ReadData;
  logic        AlignErr;
  logic [2:0]  State;
  logic [31:0] RamAddr;
  logic        RamWr;
  logic [31:0] RamDatain;
  logic [31:0] RamDataout;

  modport slave (
    input  Req, Wr, Size, Address, WriteData, RamDataout,
    output Ready, Done, ReadData, AlignErr, State, RamAddr, RamWr, RamDatain
  );

  modport master (
    output Req, Wr, Size, Address, WriteData, RamDataout,
    input  Ready, Done, ReadData, AlignErr, State, RamAddr, RamWr, RamDatain
  );
endinterface

// File: rtl/mem_bridge.sv
// ---------------------------------------------------------------------------
// mem_bridge
//   Memory-side responder for the multicycle MIPS memory port. Takes one
//   request per Req/Ready handshake and serves it against a single-port
//   synchronous RAM with RD_LAT cycles of read latency.
//     - word loads/stores pass straight through
//     - half/byte loads are zero-extended from the addressed lane
//     - half/byte stores are done as read-modify-write
//   Done pulses for one cycle at completion.
//
// Parameters:
//   RD_LAT  cycles from RamAddr to valid RamDataout (1..7)
//
// Ports:
//   Clk, Reset  clock and synchronous active-high reset
//   bus         mem_bridge_if.slave (handshake, load result, debug state,
//               RAM address/write-enable/data)
//
// Build option:
//   MEM_BRIDGE_ALIGN_CHECK_EN  when defined, misaligned word/half requests
//   skip the RAM and complete with AlignErr=1. When undefined, the low
//   address bits that cannot matter for the size are ignored.
// ---------------------------------------------------------------------------
module mem_bridge #(
  parameter int RD_LAT = 1
) (
  input logic         Clk,
  input logic         Reset,
  mem_bridge_if.slave bus
);

  localparam logic [2:0] RD_LAST = 3'(RD_LAT);

  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_BYTE = 2'b10;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_READ  = 3'd1,
    S_WRITE = 3'd2,
    S_DONE  = 3'd3
  } state_t;

  state_t      state_q, state_d;
  logic [2:0]  cnt_q, cnt_d;
  logic        wr_q, wr_d;
  logic [1:0]  size_q, size_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic [31:0] word_q, word_d;
  logic [31:0] rdata_q, rdata_d;
`ifdef MEM_BRIDGE_ALIGN_CHECK_EN
  logic        err_q, err_d;
`endif

  // Half and byte accesses are the ones that touch a single lane.
  function automatic logic is_sub(input logic [1:0] size);
    return (size == SZ_HALF) || (size == SZ_BYTE);
  endfunction

  // Zero-extended lane extraction; size 11 behaves as word.
  function automatic logic [31:0] load_extract(input logic [31:0] word,
                                               input logic [1:0]  size,
                                               input logic [1:0]  off);
    logic [31:0] res;
    res = word;
    case (size)
      SZ_HALF: res = off[1] ? {16'h0, word[31:16]} : {16'h0, word[15:0]};
      SZ_BYTE: begin
        case (off)
          2'd0:    res = {24'h0, word[7:0]};
          2'd1:    res = {24'h0, word[15:8]};
          2'd2:    res = {24'h0, word[23:16]};
          default: res = {24'h0, word[31:24]};
        endcase
      end
      default: res = word;
    endcase
    return res;
  endfunction

  // Replace only the addressed lane of the captured word.
  function automatic logic [31:0] lane_merge(input logic [31:0] word,
                                             input logic [31:0] wdata,
                                             input logic [1:0]  size,
                                             input logic [1:0]  off);
    logic [31:0] res;
    res = word;
    case (size)
      SZ_HALF: begin
        if (off[1]) res[31:16] = wdata[15:0];
        else        res[15:0]  = wdata[15:0];
      end
      SZ_BYTE: begin
        case (off)
          2'd0:    res[7:0]   = wdata[7:0];
          2'd1:    res[15:8]  = wdata[7:0];
          2'd2:    res[23:16] = wdata[7:0];
          default: res[31:24] = wdata[7:0];
        endcase
      end
      default: res = wdata;
    endcase
    return res;
  endfunction

`ifdef MEM_BRIDGE_ALIGN_CHECK_EN
  function automatic logic is_misaligned(input logic [1:0] size,
                                         input logic [1:0] off);
    logic res;
    case (size)
      SZ_HALF: res = off[0];
      SZ_BYTE: res = 1'b0;
      default: res = (off != 2'b00);
    endcase
    return res;
  endfunction
`endif

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    wr_d    = wr_q;
    size_d  = size_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    word_d  = word_q;
    rdata_d = rdata_q;
`ifdef MEM_BRIDGE_ALIGN_CHECK_EN
    err_d   = err_q;
`endif

    case (state_q)
      S_IDLE: begin
        cnt_d = 3'd0;
        if (bus.Req) begin
          wr_d    = bus.Wr;
          size_d  = bus.Size;
          addr_d  = bus.Address;
          wdata_d = bus.WriteData;
          // Only a full-word store can skip the read; sub-word stores
          // need the old word for the merge.
          if (bus.Wr && !is_sub(bus.Size)) state_d = S_WRITE;
          else                             state_d = S_READ;
`ifdef MEM_BRIDGE_ALIGN_CHECK_EN
          err_d = is_misaligned(bus.Size, bus.Address[1:0]);
          if (err_d) state_d = S_DONE;
`endif
        end
      end

      S_READ: begin
        // RamAddr has been stable since acceptance; the word is valid by
        // the (RD_LAT+1)-th READ edge.
        if (cnt_q == RD_LAST) begin
          if (wr_q) begin
            word_d  = bus.RamDataout;
            state_d = S_WRITE;
          end else begin
            rdata_d = load_extract(bus.RamDataout, size_q, addr_q[1:0]);
            state_d = S_DONE;
          end
        end else begin
          cnt_d = cnt_q + 3'd1;
        end
      end

      S_WRITE: state_d = S_DONE;

      S_DONE: begin
        state_d = S_IDLE;
`ifdef MEM_BRIDGE_ALIGN_CHECK_EN
        err_d   = 1'b0;
`endif
      end

      default: state_d = S_IDLE;
    endcase
  end

  // Reset pulls everything back to IDLE on the same edge, so an interrupted
  // read-modify-write never reaches WRITE and nothing is replayed.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q <= S_IDLE;
      cnt_q   <= 3'd0;
      wr_q    <= 1'b0;
      size_q  <= 2'b00;
      addr_q  <= 32'h0;
      wdata_q <= 32'h0;
      word_q  <= 32'h0;
      rdata_q <= 32'h0;
`ifdef MEM_BRIDGE_ALIGN_CHECK_EN
      err_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      wr_q    <= wr_d;
      size_q  <= size_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      word_q  <= word_d;
      rdata_q <= rdata_d;
`ifdef MEM_BRIDGE_ALIGN_CHECK_EN
      err_q   <= err_d;
`endif
    end
  end

  assign bus.Ready     = (state_q == S_IDLE);
  assign bus.Done      = (state_q == S_DONE);
  assign bus.RamWr     = (state_q == S_WRITE);
  assign bus.State     = state_q;
  assign bus.ReadData  = rdata_q;
  assign bus.RamAddr   = {addr_q[31:2], 2'b00};
  assign bus.RamDatain = is_sub(size_q) ? lane_merge(word_q, wdata_q, size_q, addr_q[1:0])
                                        : wdata_q;
`ifdef MEM_BRIDGE_ALIGN_CHECK_EN
  assign bus.AlignErr  = (state_q == S_DONE) && err_q;
`else
  assign bus.AlignErr  = 1'b0;
`endif

endmodule

// File: tb/tb_mem_bridge.sv
module tb_mem_bridge;
  localparam logic [1:0] SZ_W = 2'b00;
  localparam logic [1:0] SZ_H = 2'b01;
  localparam logic [1:0] SZ_B = 2'b10;
  localparam logic [1:0] SZ_X = 2'b11;

  typedef struct {
    string       tag;
    int          lat;
    int          nwr;
    logic [31:0] din;
    logic        chk_rd;
    logic [31:0] rd;
    logic        aerr;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;
  int   wr_cnt_a = 0;
  int   n_chk = 0;
  int   n_pass = 0;

  exp_t        sb_a[$];
  exp_t        sb_b[$];
  int          acc_cyc[2];
  int          nwr_m[2];
  logic [31:0] din_m[2];
  int          extra_done[2];

  mem_bridge_if bifa();
  mem_bridge_if bifb();

  mem_bridge #(.RD_LAT(1)) dut_a (.Clk(clk), .Reset(rst), .bus(bifa));
  mem_bridge #(.RD_LAT(3)) dut_b (.Clk(clk), .Reset(rst), .bus(bifb));

  always #5 clk = ~clk;

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (bifa.RamWr) wr_cnt_a <= wr_cnt_a + 1;
  end

  // RAM for dut_a: one cycle of read latency
  logic [31:0] mem_a [64];
  logic [31:0] dout_a;
  always @(posedge clk) begin
    if (bifa.RamWr) mem_a[bifa.RamAddr[7:2]] <= bifa.RamDatain;
    dout_a <= mem_a[bifa.RamAddr[7:2]];
  end
  assign bifa.RamDataout = dout_a;

  // RAM for dut_b: three cycles of read latency
  logic [31:0] mem_b [64];
  logic [31:0] pb0, pb1, pb2;
  always @(posedge clk) begin
    if (bifb.RamWr) mem_b[bifb.RamAddr[7:2]] <= bifb.RamDatain;
    pb0 <= mem_b[bifb.RamAddr[7:2]];
    pb1 <= pb0;
    pb2 <= pb1;
  end
  assign bifb.RamDataout = pb2;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
  endtask

  function automatic int sb_size(input int w);
    return (w == 0) ? sb_a.size() : sb_b.size();
  endfunction

  function automatic logic ready_of(input int w);
    return (w == 0) ? bifa.Ready : bifb.Ready;
  endfunction

  task automatic sb_pop(input int w, output exp_t e);
    if (w == 0) e = sb_a.pop_front();
    else        e = sb_b.pop_front();
  endtask

  task automatic drive(input int w, input logic req, input logic wr, input logic [1:0] sz,
                       input logic [31:0] a, input logic [31:0] wd);
    if (w == 0) begin
      bifa.Req = req; bifa.Wr = wr; bifa.Size = sz; bifa.Address = a; bifa.WriteData = wd;
    end else begin
      bifb.Req = req; bifb.Wr = wr; bifb.Size = sz; bifb.Address = a; bifb.WriteData = wd;
    end
  endtask

  // Monitor: latency counted in rising edges from acceptance to the edge
  // at which Done is first seen high.
  task automatic mon_step(input int w, input logic ready, input logic req, input logic done,
                          input logic ramwr, input logic [31:0] din, input logic [31:0] rdata,
                          input logic aerr);
    exp_t e;
    if (rst) begin
      nwr_m[w] = 0;
      return;
    end
    if (ramwr) begin
      nwr_m[w]++;
      din_m[w] = din;
    end
    if (done) begin
      if (sb_size(w) == 0) begin
        extra_done[w]++;
      end else begin
        sb_pop(w, e);
        check({e.tag, " latency"}, 32'(cyc - acc_cyc[w]), 32'(e.lat));
        check({e.tag, " ram_writes"}, 32'(nwr_m[w]), 32'(e.nwr));
        if (e.nwr > 0) check({e.tag, " RamDatain"}, din_m[w], e.din);
        if (e.chk_rd) check({e.tag, " ReadData"}, rdata, e.rd);
        check({e.tag, " AlignErr"}, {31'b0, aerr}, {31'b0, e.aerr});
      end
      nwr_m[w] = 0;
    end
    if (ready && req) begin
      acc_cyc[w] = cyc;
      nwr_m[w]   = 0;
    end
  endtask

  initial begin
    for (int i = 0; i < 2; i++) begin
      acc_cyc[i] = 0; nwr_m[i] = 0; din_m[i] = 32'h0; extra_done[i] = 0;
    end
    forever begin
      @(negedge clk);
      mon_step(0, bifa.Ready, bifa.Req, bifa.Done, bifa.RamWr, bifa.RamDatain, bifa.ReadData, bifa.AlignErr);
      mon_step(1, bifb.Ready, bifb.Req, bifb.Done, bifb.RamWr, bifb.RamDatain, bifb.ReadData, bifb.AlignErr);
    end
  end

  task automatic issue(input int w, input logic wr, input logic [1:0] sz, input logic [31:0] a,
                       input logic [31:0] wd, input int lat, input int nwr, input logic [31:0] din,
                       input logic chk_rd, input logic [31:0] rd, input logic aerr,
                       input string tag, input logic mid_pulse);
    exp_t e;
    int   n;
    n = 0;
    @(posedge clk); #1;
    while (!ready_of(w) && n < 50) begin
      @(posedge clk); #1;
      n++;
    end
    if (!ready_of(w)) begin
      n_chk++;
      $display("FAIL %s: Ready never seen, got 0, expected 1", tag);
      return;
    end
    e.tag = tag; e.lat = lat; e.nwr = nwr; e.din = din; e.chk_rd = chk_rd; e.rd = rd; e.aerr = aerr;
    if (w == 0) sb_a.push_back(e);
    else        sb_b.push_back(e);
    drive(w, 1'b1, wr, sz, a, wd);
    @(posedge clk); #1;
    // scramble inputs after acceptance; the bridge must have registered them
    drive(w, 1'b0, ~wr, SZ_X, 32'hFFFF_FFFF, ~wd);
    if (mid_pulse) begin
      @(posedge clk); #1;
      drive(w, 1'b1, 1'b1, SZ_W, 32'h20, 32'hBAD0_BAD0);
      @(posedge clk); #1;
      drive(w, 1'b0, 1'b0, SZ_W, 32'h0, 32'h0);
    end
    n = 0;
    while (sb_size(w) != 0 && n < 50) begin
      @(posedge clk);
      n++;
    end
    if (sb_size(w) != 0) begin
      n_chk++;
      $display("FAIL %s: Done never seen, got 0, expected 1", tag);
      if (w == 0) sb_a.delete();
      else        sb_b.delete();
    end
  endtask

  initial begin
    #300000;
    $display("FAIL global_timeout: got timeout, expected completion");
    $fatal(1, "simulation time limit");
  end

  initial begin
    int snap;
    drive(0, 1'b0, 1'b0, SZ_W, 32'h0, 32'h0);
    drive(1, 1'b0, 1'b0, SZ_W, 32'h0, 32'h0);
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;

    check("reset Ready",     32'(bifa.Ready),    32'd1);
    check("reset Done",      32'(bifa.Done),     32'd0);
    check("reset ReadData",  bifa.ReadData,      32'h0);
    check("reset AlignErr",  32'(bifa.AlignErr), 32'd0);
    check("reset RamWr",     32'(bifa.RamWr),    32'd0);
    check("reset RamAddr",   bifa.RamAddr,       32'h0);
    check("reset RamDatain", bifa.RamDatain,     32'h0);
    check("reset State",     32'(bifa.State),    32'd0);

    issue(0, 1'b1, SZ_W, 32'h40, 32'hDEAD_BEEF, 2, 1, 32'hDEAD_BEEF, 1'b0, 32'h0, 1'b0, "st_word", 1'b0);
    issue(0, 1'b0, SZ_W, 32'h40, 32'h0, 3, 0, 32'h0, 1'b1, 32'hDEAD_BEEF, 1'b0, "ld_word", 1'b0);
    issue(0, 1'b1, SZ_W, 32'h40, 32'h1122_3344, 2, 1, 32'h1122_3344, 1'b0, 32'h0, 1'b0, "st_word2", 1'b0);
    issue(0, 1'b1, SZ_B, 32'h42, 32'hFFFF_FFAB, 4, 1, 32'h11AB_3344, 1'b0, 32'h0, 1'b0, "st_byte", 1'b0);
    issue(0, 1'b0, SZ_W, 32'h40, 32'h0, 3, 0, 32'h0, 1'b1, 32'h11AB_3344, 1'b0, "ld_after_byte", 1'b0);
    issue(0, 1'b1, SZ_H, 32'h40, 32'h1234_5566, 4, 1, 32'h11AB_5566, 1'b0, 32'h0, 1'b0, "st_half", 1'b0);
    issue(0, 1'b1, SZ_W, 32'h40, 32'h8899_AABB, 2, 1, 32'h8899_AABB, 1'b0, 32'h0, 1'b0, "st_word3", 1'b0);
    issue(0, 1'b0, SZ_H, 32'h42, 32'h0, 3, 0, 32'h0, 1'b1, 32'h0000_8899, 1'b0, "ld_half42", 1'b0);
    issue(0, 1'b0, SZ_B, 32'h41, 32'h0, 3, 0, 32'h0, 1'b1, 32'h0000_00AA, 1'b0, "ld_byte41", 1'b0);
    issue(0, 1'b0, SZ_X, 32'h40, 32'h0, 3, 0, 32'h0, 1'b1, 32'h8899_AABB, 1'b0, "ld_size11", 1'b0);
    issue(0, 1'b0, SZ_B, 32'h43, 32'h0, 3, 0, 32'h0, 1'b1, 32'h0000_0088, 1'b0, "ld_byte43", 1'b0);

    // reset during the READ phase of a half store
    @(posedge clk); #1;
    drive(0, 1'b1, 1'b1, SZ_H, 32'h40, 32'h0000_1234);
    @(posedge clk); #1;
    drive(0, 1'b0, 1'b0, SZ_W, 32'h0, 32'h0);
    check("rmw in READ", 32'(bifa.State), 32'd1);
    snap = wr_cnt_a;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    check("ready after reset", 32'(bifa.Ready), 32'd1);
    check("RamWr after reset", 32'(bifa.RamWr), 32'd0);
    repeat (4) @(posedge clk);
    #1;
    check("no write after reset", 32'(wr_cnt_a), 32'(snap));
    issue(0, 1'b0, SZ_W, 32'h40, 32'h0, 3, 0, 32'h0, 1'b1, 32'h8899_AABB, 1'b0, "ld_after_reset", 1'b0);
    issue(0, 1'b0, SZ_B, 32'h43, 32'h0, 3, 0, 32'h0, 1'b1, 32'h0000_0088, 1'b0, "ld_byte43b", 1'b0);

`ifdef MEM_BRIDGE_ALIGN_CHECK_EN
    issue(0, 1'b0, SZ_W, 32'h41, 32'h0, 1, 0, 32'h0, 1'b1, 32'h0000_0088, 1'b1, "ld_word_misaligned", 1'b0);
    issue(0, 1'b0, SZ_H, 32'h43, 32'h0, 1, 0, 32'h0, 1'b1, 32'h0000_0088, 1'b1, "ld_half_misaligned", 1'b0);
    issue(0, 1'b1, SZ_H, 32'h41, 32'h0000_CCDD, 1, 0, 32'h0, 1'b1, 32'h0000_0088, 1'b1, "st_half_misaligned", 1'b0);
    issue(0, 1'b0, SZ_W, 32'h40, 32'h0, 3, 0, 32'h0, 1'b1, 32'h8899_AABB, 1'b0, "ld_final", 1'b0);
`else
    issue(0, 1'b0, SZ_W, 32'h41, 32'h0, 3, 0, 32'h0, 1'b1, 32'h8899_AABB, 1'b0, "ld_word_unaligned", 1'b0);
    issue(0, 1'b0, SZ_H, 32'h43, 32'h0, 3, 0, 32'h0, 1'b1, 32'h0000_8899, 1'b0, "ld_half_unaligned", 1'b0);
    issue(0, 1'b1, SZ_H, 32'h41, 32'h0000_CCDD, 4, 1, 32'h8899_CCDD, 1'b0, 32'h0, 1'b0, "st_half_unaligned", 1'b0);
    issue(0, 1'b0, SZ_W, 32'h40, 32'h0, 3, 0, 32'h0, 1'b1, 32'h8899_CCDD, 1'b0, "ld_final", 1'b0);
`endif

    issue(1, 1'b1, SZ_W, 32'h10, 32'hCAFE_F00D, 2, 1, 32'hCAFE_F00D, 1'b0, 32'h0, 1'b0, "b_st10", 1'b0);
    issue(1, 1'b1, SZ_W, 32'h20, 32'h5A5A_5A5A, 2, 1, 32'h5A5A_5A5A, 1'b0, 32'h0, 1'b0, "b_st20", 1'b0);
    issue(1, 1'b0, SZ_W, 32'h10, 32'h0, 5, 0, 32'h0, 1'b1, 32'hCAFE_F00D, 1'b0, "b_ld_lat3", 1'b1);
    issue(1, 1'b0, SZ_W, 32'h20, 32'h0, 5, 0, 32'h0, 1'b1, 32'h5A5A_5A5A, 1'b0, "b_ld_after_pulse", 1'b0);

    repeat (10) @(posedge clk);
    #1;
    check("extra Done a", 32'(extra_done[0]), 32'd0);
    check("extra Done b", 32'(extra_done[1]), 32'd0);
    check("pending a", 32'(sb_a.size()), 32'd0);
    check("pending b", 32'(sb_b.size()), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
